multicycle_ctrl: RTL

Multicycle control sequencer for the processor datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the per-cycle strobes consumed by the register file, ALU control, operand muxes, PC and instruction register. It sits beside the decode stage and replaces the purely combinational control-bit decode with a state machine. It also handshakes with the unified memory port and counts retired instructions.

---
 rtl/ctrl_pkg.sv | 36 +++
 rtl/multicycle_ctrl_if.sv | 11 +
 rtl/ctrl_outputs.sv | 93 +++++++++
 rtl/multicycle_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: state codes, opcodes,
// ALU operation classes and PC source selects.
package ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    localparam logic [2:0] ST_TRAP   = 3'd6;
`endif

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // Opcodes that continue past DECODE into EXEC.
    function automatic logic needs_exec(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port handshake between the sequencer (master) and memory (slave).
interface multicycle_ctrl_if;

    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);

endinterface

// File: rtl/ctrl_outputs.sv
// Combinational strobe decode from (state, current opcode, zero, mem_ack).
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds the TRAP state and the illegal_op flag.
module ctrl_outputs
    import ctrl_pkg::*;
(
    input  logic [2:0] state,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       rf_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic [1:0] alu_op,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal_op,
`endif
    output logic       retire
);

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        rf_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        retire     = 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        illegal_op = 1'b0;
`endif
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_DECODE: begin
                if (op == OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    retire   = 1'b1;
                end
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                // Illegal opcodes complete here as a NOP.
                else if (!needs_exec(op)) begin
                    retire = 1'b1;
                end
`endif
            end
            ST_EXEC: begin
                case (op)
                    OP_R: alu_op = ALU_FUNCT;
                    OP_LW, OP_SW, OP_ADDI: alu_src = 1'b1;
                    OP_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BRANCH;
                        pc_write = zero;
                        retire   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op == OP_SW);
                retire  = mem_ack && (op == OP_SW);
            end
            ST_WB: begin
                rf_write   = 1'b1;
                reg_dst    = (op == OP_R);
                mem_to_reg = (op == OP_LW);
                retire     = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: illegal_op = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: state register, latched opcode and retired counter.
// Optional illegal-opcode trap is enabled by defining MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    multicycle_ctrl_if.master mem,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             rf_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output logic             illegal_op,
`endif
    output logic [CNT_W-1:0] retired
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [5:0] op_q;
    logic [5:0] cur_op;
    logic       retire;

    // op_q is only loaded at the end of DECODE, so DECODE itself looks at the IR directly.
    assign cur_op = (state == ST_DECODE) ? opcode : op_q;

    ctrl_outputs u_outputs (
        .state      (state),
        .op         (cur_op),
        .zero       (zero),
        .mem_ack    (mem.mem_ack),
        .mem_req    (mem.mem_req),
        .mem_we     (mem.mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .rf_write   (rf_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        .illegal_op (illegal_op),
`endif
        .retire     (retire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: if (mem.mem_ack) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_J)
                    state_nxt = ST_FETCH;
                else if (needs_exec(opcode))
                    state_nxt = ST_EXEC;
                else
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    state_nxt = ST_TRAP;
`else
                    state_nxt = ST_FETCH;
`endif
            end
            ST_EXEC: begin
                case (op_q)
                    OP_R, OP_ADDI: state_nxt = ST_WB;
                    OP_LW, OP_SW:  state_nxt = ST_MEM;
                    default:       state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem.mem_ack)
                    state_nxt = (op_q == OP_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB: state_nxt = ST_FETCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: state_nxt = ST_TRAP;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE)
                op_q <= opcode;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule
